// File: rtl/pipeline_pkg.sv
// Shared state and command encodings for the pipeline run-control sequencer.
package pipeline_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned CMD_W   = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_STEP_EXEC = 3'd2,
    ST_STEP_WAIT = 3'd3,
    ST_DRAIN     = 3'd4,
    ST_DONE      = 3'd5
  } state_e;

  localparam logic [CMD_W-1:0] CMD_NOP  = 2'b00;
  localparam logic [CMD_W-1:0] CMD_RUN  = 2'b01;
  localparam logic [CMD_W-1:0] CMD_STEP = 2'b10;
  localparam logic [CMD_W-1:0] CMD_STOP = 2'b11;

endpackage : pipeline_pkg

// File: rtl/pipeline_sequencer.sv
// Run-control sequencer: merges hazard stall, branch squash and debug
// run/step/stop with halt draining into per-stage enables and flushes.
module pipeline_sequencer
  import pipeline_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_cmd_valid,
  input  logic [CMD_W-1:0]   i_cmd,
  output logic               o_cmd_ready,
  input  logic               i_stall,
  input  logic               i_branch_taken,
  input  logic               i_halt_ID,
  input  logic               i_halt_WB,
  output logic               o_pc_en,
  output logic               o_if_id_en,
  output logic               o_if_id_flush,
  output logic               o_id_ex_flush,
  output logic               o_ex_mem_en,
  output logic               o_mem_wb_en,
  output logic [STATE_W-1:0] o_state,
  output logic               o_done,
  output logic [CNT_W-1:0]   o_cycle_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             cmd_acc;
  logic             active;
  logic             cnt_clr;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state and zero-latency stage controls
  always_comb begin
    state_d       = state_q;
    o_cmd_ready   = 1'b1;
    o_pc_en       = 1'b0;
    o_if_id_en    = 1'b0;
    o_if_id_flush = 1'b0;
    o_id_ex_flush = 1'b0;
    o_ex_mem_en   = 1'b0;
    o_mem_wb_en   = 1'b0;
    o_done        = 1'b0;
    active        = 1'b0;
    cnt_clr       = 1'b0;

    if ((state_q == ST_STEP_EXEC) || (state_q == ST_DRAIN)) o_cmd_ready = 1'b0;
    cmd_acc = i_cmd_valid && o_cmd_ready;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_acc && (i_cmd == CMD_RUN)) begin
          state_d = ST_RUN;
          cnt_clr = 1'b1;
        end else if (cmd_acc && (i_cmd == CMD_STEP)) begin
          state_d = ST_STEP_EXEC;
          cnt_clr = 1'b1;
        end
      end
      ST_RUN, ST_STEP_EXEC: begin
        active      = 1'b1;
        o_ex_mem_en = 1'b1;
        o_mem_wb_en = 1'b1;
        if (i_stall) begin
          // Hold PC and IF/ID, inject a bubble; branch and halt wait
          o_id_ex_flush = 1'b1;
        end else begin
          o_pc_en       = !i_halt_ID;
          o_if_id_en    = 1'b1;
          o_if_id_flush = i_branch_taken || i_halt_ID;
        end
        if (state_q == ST_STEP_EXEC) begin
          state_d = (!i_stall && i_halt_ID) ? ST_DRAIN : ST_STEP_WAIT;
        end else if (cmd_acc && (i_cmd == CMD_STOP)) begin
          state_d = ST_IDLE;
        end else if (!i_stall && i_halt_ID) begin
          state_d = ST_DRAIN;
        end
      end
      ST_STEP_WAIT: begin
        if (cmd_acc) begin
          unique case (i_cmd)
            CMD_STEP: state_d = ST_STEP_EXEC;
            CMD_RUN:  state_d = ST_RUN;
            CMD_STOP: state_d = ST_IDLE;
            default:  state_d = ST_STEP_WAIT;
          endcase
        end
      end
      ST_DRAIN: begin
        // Squash fetch, let older instructions retire regardless of stall
        active        = 1'b1;
        o_if_id_en    = 1'b1;
        o_if_id_flush = 1'b1;
        o_ex_mem_en   = 1'b1;
        o_mem_wb_en   = 1'b1;
        if (i_halt_WB) state_d = ST_DONE;
      end
      ST_DONE: begin
        o_done = 1'b1;
        if (cmd_acc && (i_cmd == CMD_STOP)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Saturating active-cycle counter, cleared on start from IDLE
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                        cnt_q <= '0;
    else if (cnt_clr)                    cnt_q <= '0;
    else if (active && (cnt_q != CNT_MAX)) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign o_state     = state_q;
  assign o_cycle_cnt = cnt_q;

endmodule : pipeline_sequencer

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer with a 3-bit counter to reach saturation.
module tb_pipeline_sequencer;
  import pipeline_pkg::*;

  localparam int unsigned CW = 3;

  // {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, mem_wb_en}
  localparam logic [5:0] EN_OFF   = 6'b000000;
  localparam logic [5:0] EN_RUN   = 6'b110011;
  localparam logic [5:0] EN_STALL = 6'b000111;
  localparam logic [5:0] EN_TAKEN = 6'b111011;
  localparam logic [5:0] EN_HALT  = 6'b011011;
  localparam logic [5:0] EN_DRAIN = 6'b011011;

  logic               i_clk = 1'b0;
  logic               i_rst_n;
  logic               i_cmd_valid;
  logic [1:0]         i_cmd;
  logic               o_cmd_ready;
  logic               i_stall;
  logic               i_branch_taken;
  logic               i_halt_ID;
  logic               i_halt_WB;
  logic               o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_flush;
  logic               o_ex_mem_en, o_mem_wb_en;
  logic [2:0]         o_state;
  logic               o_done;
  logic [CW-1:0]      o_cycle_cnt;
  logic [5:0]         en_vec;

  int n_chk  = 0;
  int n_pass = 0;

  pipeline_sequencer #(.CNT_W(CW)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_cmd_valid    (i_cmd_valid),
    .i_cmd          (i_cmd),
    .o_cmd_ready    (o_cmd_ready),
    .i_stall        (i_stall),
    .i_branch_taken (i_branch_taken),
    .i_halt_ID      (i_halt_ID),
    .i_halt_WB      (i_halt_WB),
    .o_pc_en        (o_pc_en),
    .o_if_id_en     (o_if_id_en),
    .o_if_id_flush  (o_if_id_flush),
    .o_id_ex_flush  (o_id_ex_flush),
    .o_ex_mem_en    (o_ex_mem_en),
    .o_mem_wb_en    (o_mem_wb_en),
    .o_state        (o_state),
    .o_done         (o_done),
    .o_cycle_cnt    (o_cycle_cnt)
  );

  always #5 i_clk = ~i_clk;

  assign en_vec = {o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_flush, o_ex_mem_en, o_mem_wb_en};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [1:0] c);
    i_cmd_valid = 1'b1;
    i_cmd       = c;
    cyc();
    i_cmd_valid = 1'b0;
    i_cmd       = CMD_NOP;
  endtask

  initial begin
    i_rst_n = 1'b0; i_cmd_valid = 1'b0; i_cmd = CMD_NOP;
    i_stall = 1'b0; i_branch_taken = 1'b0; i_halt_ID = 1'b0; i_halt_WB = 1'b0;
    #12;
    chk("rst_state", 32'(o_state), 32'd0);
    chk("rst_en", 32'(en_vec), 32'(EN_OFF));
    chk("rst_cnt", 32'(o_cycle_cnt), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_ready", 32'(o_cmd_ready), 32'd1);
    i_rst_n = 1'b1;
    cyc();

    // 1: RUN for five clean cycles
    chk("idle_en", 32'(en_vec), 32'(EN_OFF));
    send(CMD_RUN);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("run_state", 32'(o_state), 32'd1);
      chk("run_en", 32'(en_vec), 32'(EN_RUN));
      cyc();
    end
    chk("run_cnt5", 32'(o_cycle_cnt), 32'd5);

    // 2: stall beats branch, then branch squashes IF/ID
    i_stall = 1'b1; i_branch_taken = 1'b1; #1;
    chk("stall_en", 32'(en_vec), 32'(EN_STALL));
    cyc();
    i_stall = 1'b0; #1;
    chk("taken_en", 32'(en_vec), 32'(EN_TAKEN));
    cyc();
    i_branch_taken = 1'b0;
    chk("cnt_reach_max", 32'(o_cycle_cnt), 32'd7);
    cyc();
    chk("cnt_saturate", 32'(o_cycle_cnt), 32'd7);

    // RUN/STEP ignored in RUN, STOP returns to IDLE holding the count
    send(CMD_STEP);
    chk("run_ign_step", 32'(o_state), 32'd1);
    send(CMD_STOP);
    chk("stop_idle", 32'(o_state), 32'd0);
    chk("stop_en", 32'(en_vec), 32'(EN_OFF));
    cyc();
    chk("idle_cnt_hold", 32'(o_cycle_cnt), 32'd7);
    send(CMD_STOP);
    chk("idle_ign_stop", 32'(o_state), 32'd0);

    // 3: three single steps, extra STEP during exec dropped
    for (int k = 1; k <= 3; k++) begin
      send(CMD_STEP);
      #1;
      chk("step_exec", 32'(o_state), 32'd2);
      chk("step_ready", 32'(o_cmd_ready), 32'd0);
      chk("step_en", 32'(en_vec), 32'(EN_RUN));
      if (k == 1) begin
        chk("step_clr", 32'(o_cycle_cnt), 32'd0);
        send(CMD_STEP);
      end else begin
        cyc();
      end
      chk("step_wait", 32'(o_state), 32'd3);
      chk("step_wait_en", 32'(en_vec), 32'(EN_OFF));
      chk("step_cnt", 32'(o_cycle_cnt), 32'(k));
      for (int g = 0; g < 3; g++) cyc();
      chk("step_gap_state", 32'(o_state), 32'd3);
      chk("step_gap_cnt", 32'(o_cycle_cnt), 32'(k));
    end

    // 4: RUN from STEP_WAIT, halt with simultaneous branch, drain, done
    send(CMD_RUN);
    chk("wait_to_run", 32'(o_state), 32'd1);
    i_halt_ID = 1'b1; i_branch_taken = 1'b1; #1;
    chk("halt_en", 32'(en_vec), 32'(EN_HALT));
    cyc();
    i_halt_ID = 1'b0; i_branch_taken = 1'b0;
    for (int d = 0; d < 3; d++) begin
      i_stall   = (d == 0);
      i_halt_WB = (d == 2);
      #1;
      chk("drain_state", 32'(o_state), 32'd4);
      chk("drain_en", 32'(en_vec), 32'(EN_DRAIN));
      chk("drain_ready", 32'(o_cmd_ready), 32'd0);
      cyc();
    end
    i_stall = 1'b0; i_halt_WB = 1'b0;
    chk("done_state", 32'(o_state), 32'd5);
    chk("done_flag", 32'(o_done), 32'd1);
    chk("done_en", 32'(en_vec), 32'(EN_OFF));
    chk("done_cnt", 32'(o_cycle_cnt), 32'd7);
    send(CMD_RUN);
    chk("done_ign_run", 32'(o_state), 32'd5);
    send(CMD_STOP);
    chk("done_stop", 32'(o_state), 32'd0);
    chk("done_clr", 32'(o_done), 32'd0);

    // 5: new RUN clears the saturated counter
    send(CMD_RUN);
    chk("rerun_clr", 32'(o_cycle_cnt), 32'd0);
    cyc();
    chk("rerun_cnt1", 32'(o_cycle_cnt), 32'd1);

    // 6: async reset mid-DRAIN, then a single step
    i_halt_ID = 1'b1;
    cyc();
    i_halt_ID = 1'b0;
    cyc();
    chk("pre_rst_drain", 32'(o_state), 32'd4);
    i_rst_n = 1'b0; #1;
    chk("arst_state", 32'(o_state), 32'd0);
    chk("arst_en", 32'(en_vec), 32'(EN_OFF));
    chk("arst_cnt", 32'(o_cycle_cnt), 32'd0);
    chk("arst_ready", 32'(o_cmd_ready), 32'd1);
    #1;
    i_rst_n = 1'b1;
    cyc();
    send(CMD_STEP);
    chk("post_rst_step", 32'(o_state), 32'd2);
    chk("post_rst_en", 32'(en_vec), 32'(EN_RUN));
    cyc();
    chk("post_rst_wait", 32'(o_state), 32'd3);
    chk("post_rst_cnt", 32'(o_cycle_cnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_pipeline_sequencer
